// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer/filter.
package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;
    localparam int SYNC_MAX_FILTER = 255;

    // Counter must hold 0..filter; never narrower than one bit.
    function automatic int cnt_width(input int filter);
        return (filter < 1) ? 1 : $clog2(filter + 1);
    endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One channel: synchronizer chain, stability counter and registered edge pulses.
module sync_filter_bit
    import sync_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter int   FILTER  = 0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int            CW      = cnt_width(FILTER);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
    logic [CW-1:0] cnt;
    logic          s;
    logic          take;

    assign s    = chain[STAGES-1];
    assign take = (s != q) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    // cnt counts consecutive mismatch cycles already seen; any match restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RST_VAL;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= take & s;
            fall <= take & ~s;
            if ((s == q) || take) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (take) begin
                q <= s;
            end
        end
    end

endmodule

// File: rtl/sync_filter_n.sv
// WIDTH independent async level inputs synchronized, stability-filtered, with edge pulses.
module sync_filter_n
    import sync_pkg::*;
#(
    parameter int               STAGES  = 2,
    parameter int               WIDTH   = 4,
    parameter int               FILTER  = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_filter_n: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end
    if ((FILTER < 0) || (FILTER > SYNC_MAX_FILTER)) begin : g_bad_filter
        $error("sync_filter_n: FILTER must be within 0..%0d", SYNC_MAX_FILTER);
    end

    // No cross-channel coherency: each bit settles on its own schedule.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_filter_bit #(
            .STAGES  (STAGES),
            .FILTER  (FILTER),
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din[i]),
            .q     (q[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_filter_n.sv
// Bench for sync_filter_n: directed vector table plus random soak over a grid of STAGES/FILTER.
module tb_sync_filter_n;

    localparam int NI = 11;

    function automatic int st_of(input int i);
        case (i)
            0, 2, 3, 6: return 2;
            1, 4, 7, 8: return 3;
            default:    return 4;
        endcase
    endfunction

    function automatic int fl_of(input int i);
        case (i)
            2:         return 3;
            3, 7, 9:   return 1;
            4:         return 5;
            6, 8, 10:  return 7;
            default:   return 0;
        endcase
    endfunction

    function automatic logic [3:0] rv_of(input int i);
        case (i)
            0:       return 4'b0101;
            10:      return 4'b1010;
            default: return 4'b0000;
        endcase
    endfunction

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] din  [NI];
    logic [3:0] q    [NI];
    logic [3:0] rise [NI];
    logic [3:0] fall [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sync_filter_n #(
            .STAGES  (st_of(g)),
            .WIDTH   (4),
            .FILTER  (fl_of(g)),
            .RST_VAL (rv_of(g))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din[g]),
            .q     (q[g]),
            .rise  (rise[g]),
            .fall  (fall[g])
        );
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference: din sample history plus per-bit count of consecutive mismatch cycles.
    logic [3:0] hist [NI][4];
    logic [3:0] mq [NI];
    logic [3:0] mr [NI];
    logic [3:0] mf [NI];
    int         run [NI][4];

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic [3:0] f;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         inst;
        logic [3:0] d;
        logic [3:0] eq;
        logic [3:0] er;
        logic [3:0] ef;
    } vec_t;
    vec_t tab[$];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got q/rise/fall %b_%b_%b want %b_%b_%b", name,
                     act[11:8], act[7:4], act[3:0], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 4; k++) hist[i][k] = rv_of(i);
            for (int b = 0; b < 4; b++) run[i][b] = 0;
            mq[i] = rv_of(i);
            mr[i] = '0;
            mf[i] = '0;
        end
    endtask

    task automatic model_clock();
        logic [3:0] s;
        for (int i = 0; i < NI; i++) begin
            s     = hist[i][st_of(i)-1];
            mr[i] = '0;
            mf[i] = '0;
            for (int b = 0; b < 4; b++) begin
                if (s[b] == mq[i][b]) begin
                    run[i][b] = 0;
                end else if (run[i][b] == fl_of(i)) begin
                    mq[i][b]  = s[b];
                    mr[i][b]  = s[b];
                    mf[i][b]  = ~s[b];
                    run[i][b] = 0;
                end else begin
                    run[i][b]++;
                end
            end
            for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = din[i];
        end
    endtask

    // One clock: model advances on the edge, expectations queued, DUT compared 1 ns later.
    task automatic step();
        exp_t e;
        @(posedge clk);
        if (rst_n) model_clock();
        else       model_reset();
        for (int i = 0; i < NI; i++) sb.push_back('{q: mq[i], r: mr[i], f: mf[i]});
        #1;
        for (int i = 0; i < NI; i++) begin
            e = sb.pop_front();
            check($sformatf("sb u%0d c%0d", i, cyc), {q[i], rise[i], fall[i]}, {e.q, e.r, e.f});
        end
        cyc++;
    endtask

    task automatic add(input int inst, input logic [3:0] d, input logic [3:0] eq,
                       input logic [3:0] er, input logic [3:0] ef);
        tab.push_back('{inst: inst, d: d, eq: eq, er: er, ef: ef});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m;

        // Idle after reset on the RST_VAL=0101 instance.
        for (int k = 0; k < 10; k++) add(0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        // Latency, STAGES=3 FILTER=0.
        for (int k = 0; k < 3; k++) add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        // Filter, STAGES=2 FILTER=3: 3-cycle glitch swallowed, 4-cycle pulse passes, then falls.
        for (int k = 0; k < 3; k++) add(2, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) add(2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 4; k++) add(2, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        add(2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(2, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
        for (int k = 0; k < 3; k++) add(2, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        add(2, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        add(2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Simultaneous change, STAGES=2 FILTER=1, bit 2 glitches back for one cycle.
        add(3, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(3, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
        add(3, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(3, 4'b1111, 4'b1011, 4'b1011, 4'b0000);
        add(3, 4'b1111, 4'b1011, 4'b0000, 4'b0000);
        add(3, 4'b1111, 4'b1111, 4'b0100, 4'b0000);
        add(3, 4'b1111, 4'b1111, 4'b0000, 4'b0000);

        for (int i = 0; i < NI; i++) din[i] = rv_of(i);
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) step();
        for (int i = 0; i < NI; i++)
            check($sformatf("reset u%0d", i), {q[i], rise[i], fall[i]}, {rv_of(i), 8'h00});
        rst_n = 1'b1;

        foreach (tab[n]) begin
            din[tab[n].inst] = tab[n].d;
            step();
            check($sformatf("tab%0d u%0d", n, tab[n].inst),
                  {q[tab[n].inst], rise[tab[n].inst], fall[tab[n].inst]},
                  {tab[n].eq, tab[n].er, tab[n].ef});
        end

        // Reset in the middle of a count (STAGES=3 FILTER=5, both bits at cnt=3).
        din[4] = 4'b0010;
        repeat (12) step();
        check("mid settled", {q[4], rise[4], fall[4]}, {4'b0010, 8'h00});
        din[4] = 4'b0001;
        repeat (6) step();
        check("mid pending", {q[4], rise[4], fall[4]}, {4'b0010, 8'h00});
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("mid async", {q[4], rise[4], fall[4]}, 12'h000);
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("mid restart wait %0d", k), {q[4], rise[4], fall[4]}, 12'h000);
        end
        step();
        check("mid restart rise", {q[4], rise[4], fall[4]}, {4'b0001, 4'b0001, 4'b0000});

        // Random soak across the STAGES x FILTER grid.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NI; i++) begin
                for (int b = 0; b < 4; b++) m[b] = ($urandom_range(0, 5) == 0);
                din[i] = din[i] ^ m;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
